noc_output_arbiter: RTL and testbench

- Per-output-port arbiter in the NoC router.
- Shares one output link among N_REQ input FIFOs (N, S, E, W, Local) using round-robin with packet lock: once a packet wins, it keeps the link until its tail flit leaves.
- Drives the one-hot rd_en back to the input FIFOs, which are first-word-fall-through (head flit visible on dout while not empty).
- Presents the selected flit to the downstream FIFO, gated by its full flag.

---
 rtl/noc_output_arbiter.sv | 95 +++++++++
 tb/tb_noc_output_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Per-output-port arbiter: round-robin among the input FIFOs with a packet lock
// held from the winning head flit until its tail flit has left.
module noc_output_arbiter #(
  parameter  int N_REQ  = 5,
  parameter  int DATA_W = 64,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_empty,
  input  logic [N_REQ-1:0]        req_hit,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        rd_en,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_full,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [CNT_W-1:0]        pkt_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] slice [N_REQ];
  logic [DATA_W-1:0] cur_flit;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  scan_pos;
  logic              xfer;
  logic              is_tail;

  assign req = ~req_empty & req_hit;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slice[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // First set request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_pos = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && req[scan_pos]) begin
        win_found = 1'b1;
        win_idx   = scan_pos;
      end
    end
  end

  // Handshake: a flit moves on any cycle with out_valid=1 and out_full=0;
  // that same condition pops the locked input FIFO through rd_en.
  assign busy      = (state == LOCK);
  assign cur_flit  = slice[grant_idx];
  assign out_data  = busy ? cur_flit : '0;
  assign out_valid = busy && !req_empty[grant_idx];
  assign xfer      = out_valid && !out_full;
  assign is_tail   = cur_flit[DATA_W-2];
  assign rd_en     = xfer ? (N_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      pkt_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (xfer && is_tail) begin
            state   <= IDLE;
            rr_ptr  <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            pkt_cnt <= pkt_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: behavioural FWFT input FIFOs feed the arbiter,
// forwarded flits are checked in order against an expected queue.
module tb_noc_output_arbiter;

  localparam int N_REQ  = 5;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 3;
  localparam int SB_W   = IDX_W + DATA_W;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_empty;
  logic [N_REQ-1:0]        req_hit;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        rd_en;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_full;
  logic                    busy;
  logic [IDX_W-1:0]        grant_idx;
  logic [CNT_W-1:0]        pkt_cnt;

  logic [DATA_W-1:0] fifo_q [N_REQ][$];
  logic [SB_W-1:0]   exp_q[$];
  logic [N_REQ-1:0]  pop_mask;
  int tests_run;
  int tests_failed;

  noc_output_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_empty (req_empty),
    .req_hit   (req_hit),
    .req_data  (req_data),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_full  (out_full),
    .busy      (busy),
    .grant_idx (grant_idx),
    .pkt_cnt   (pkt_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  function automatic logic [DATA_W-1:0] mk(input logic h, input logic t, input logic [15:0] p);
    return {h, t, {(DATA_W-18){1'b0}}, p};
  endfunction

  task automatic refresh_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      if (fifo_q[i].size() > 0) begin
        req_empty[i] = 1'b0;
        req_data[i*DATA_W +: DATA_W] = fifo_q[i][0];
      end else begin
        req_empty[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic push_flit(input int idx, input logic [DATA_W-1:0] f);
    fifo_q[idx].push_back(f);
    refresh_inputs();
  endtask

  task automatic expect_flit(input int idx, input logic [DATA_W-1:0] f);
    exp_q.push_back({IDX_W'(idx), f});
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_full = 1'b0;
    req_hit = '1;
    for (int i = 0; i < N_REQ; i++) fifo_q[i].delete();
    exp_q.delete();
    refresh_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      wait_cycle();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0 || busy) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d flits pending, busy=%b, want 0 pending and busy=0", name, exp_q.size(), busy);
    end
  endtask

  // input FIFO model: pop on the edge where rd_en was high
  always @(posedge clk) begin
    pop_mask = rd_en;
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (pop_mask[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    end
    refresh_inputs();
  end

  // scoreboard
  logic             exp_valid;
  logic [N_REQ-1:0] exp_rd;
  logic [SB_W-1:0]  exp_e;
  always @(negedge clk) begin
    if (rst) begin
      exp_valid = busy && (fifo_q[grant_idx].size() > 0);
      exp_rd    = (exp_valid && !out_full) ? (N_REQ'(1) << grant_idx) : '0;
      tests_run++;
      if (out_valid !== exp_valid || rd_en !== exp_rd) begin
        tests_failed++;
        $display("FAIL handshake @%0t: out_valid=%b rd_en=%b, want out_valid=%b rd_en=%b",
                 $time, out_valid, rd_en, exp_valid, exp_rd);
      end
      if (exp_valid && !out_full) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL flit @%0t: got idx=%0d data=%h, want no flit", $time, grant_idx, out_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({grant_idx, out_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL flit @%0t: got idx=%0d data=%h, want idx=%0d data=%h", $time,
                     grant_idx, out_data, exp_e[SB_W-1 -: IDX_W], exp_e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, rd_en, out_valid, grant_idx, pkt_cnt, out_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: busy=%b rd_en=%b out_valid=%b grant=%0d pkt_cnt=%0d out_data=%h, want all 0",
               busy, rd_en, out_valid, grant_idx, pkt_cnt, out_data);
    end
    rst = 1'b1;
    wait_cycle();
    tests_run++;
    if (busy !== 1'b0 || rd_en !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b rd_en=%b, want 0/00000", busy, rd_en);
    end
  endtask

  task automatic test_single_flit();
    logic [DATA_W-1:0] f;
    do_reset();
    f = mk(1'b1, 1'b1, 16'h00AB);
    req_hit = 5'b00100;
    push_flit(2, f);
    push_flit(4, mk(1'b1, 1'b1, 16'h0444));
    expect_flit(2, f);
    wait_cycle();
    tests_run++;
    if (busy !== 1'b1 || grant_idx !== 3'd2 || out_valid !== 1'b1 || rd_en !== 5'b00100 ||
        out_data !== 64'hC000_0000_0000_00AB) begin
      tests_failed++;
      $display("FAIL single_c1: busy=%b grant=%0d valid=%b rd_en=%b data=%h, want 1/2/1/00100/c0000000000000ab",
               busy, grant_idx, out_valid, rd_en, out_data);
    end
    wait_cycle();
    tests_run++;
    if (busy !== 1'b0 || pkt_cnt !== 16'd1 || rd_en !== '0) begin
      tests_failed++;
      $display("FAIL single_c2: busy=%b pkt_cnt=%0d rd_en=%b, want 0/1/00000", busy, pkt_cnt, rd_en);
    end
    repeat (4) wait_cycle();
    wait_idle("single");
    tests_run++;
    if (fifo_q[4].size() != 1) begin
      tests_failed++;
      $display("FAIL single_nohit: fifo4 depth=%0d, want 1 (req_hit[4]=0)", fifo_q[4].size());
    end
  endtask

  task automatic test_round_robin();
    int cyc[$];
    int idx[$];
    int want_idx[4];
    logic chk_cnt;
    do_reset();
    want_idx = '{0, 1, 3, 0};
    push_flit(0, mk(1'b1, 1'b1, 16'h0A00));
    push_flit(1, mk(1'b1, 1'b1, 16'h0A01));
    push_flit(3, mk(1'b1, 1'b1, 16'h0A03));
    expect_flit(0, mk(1'b1, 1'b1, 16'h0A00));
    expect_flit(1, mk(1'b1, 1'b1, 16'h0A01));
    expect_flit(3, mk(1'b1, 1'b1, 16'h0A03));
    expect_flit(0, mk(1'b1, 1'b1, 16'h0B00));
    chk_cnt = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      wait_cycle();
      if (chk_cnt) begin
        chk_cnt = 1'b0;
        tests_run++;
        if (pkt_cnt !== 16'd3) begin
          tests_failed++;
          $display("FAIL rr_pkt_cnt: got %0d, want 3", pkt_cnt);
        end
      end
      if (rd_en !== '0) begin
        cyc.push_back(c);
        idx.push_back(int'(grant_idx));
        if (cyc.size() == 3) begin
          push_flit(0, mk(1'b1, 1'b1, 16'h0B00));
          chk_cnt = 1'b1;
        end
      end
    end
    tests_run++;
    if (cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d transfers, want 4", cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (idx[k] != want_idx[k] || cyc[k] != 2 * k + 1) begin
          tests_failed++;
          $display("FAIL rr_order[%0d]: got idx=%0d cycle=%0d, want idx=%0d cycle=%0d",
                   k, idx[k], cyc[k], want_idx[k], 2 * k + 1);
        end
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_packet_lock();
    logic [DATA_W-1:0] p [4];
    do_reset();
    push_flit(3, mk(1'b1, 1'b1, 16'h0C03));
    expect_flit(3, mk(1'b1, 1'b1, 16'h0C03));
    wait_idle("lock_pre");
    p[0] = mk(1'b1, 1'b0, 16'h4000);
    p[1] = mk(1'b0, 1'b0, 16'h4001);
    p[2] = mk(1'b0, 1'b0, 16'h4002);
    p[3] = mk(1'b0, 1'b1, 16'h4003);
    for (int k = 0; k < 4; k++) begin
      push_flit(4, p[k]);
      expect_flit(4, p[k]);
    end
    push_flit(0, mk(1'b1, 1'b1, 16'h0C00));
    expect_flit(0, mk(1'b1, 1'b1, 16'h0C00));
    for (int c = 1; c <= 4; c++) begin
      wait_cycle();
      tests_run++;
      if (rd_en !== 5'b10000) begin
        tests_failed++;
        $display("FAIL lock_b2b c%0d: rd_en=%b, want 10000", c, rd_en);
      end
    end
    wait_cycle();
    tests_run++;
    if (rd_en !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_bubble: rd_en=%b busy=%b, want 00000/0", rd_en, busy);
    end
    wait_idle("lock");
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] p [3];
    do_reset();
    p[0] = mk(1'b1, 1'b0, 16'h1100);
    p[1] = mk(1'b0, 1'b0, 16'h1101);
    p[2] = mk(1'b0, 1'b1, 16'h1102);
    for (int k = 0; k < 3; k++) begin
      push_flit(1, p[k]);
      expect_flit(1, p[k]);
    end
    wait_cycle();
    tests_run++;
    if (rd_en !== 5'b00010) begin
      tests_failed++;
      $display("FAIL bp_first: rd_en=%b, want 00010", rd_en);
    end
    for (int k = 0; k < 3; k++) begin
      wait_cycle();
      out_full = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || rd_en !== '0 || out_data !== p[1]) begin
        tests_failed++;
        $display("FAIL bp_stall[%0d]: valid=%b rd_en=%b data=%h, want 1/00000/%h",
                 k, out_valid, rd_en, out_data, p[1]);
      end
    end
    wait_cycle();
    out_full = 1'b0;
    #1;
    tests_run++;
    if (rd_en !== 5'b00010 || out_data !== p[1]) begin
      tests_failed++;
      $display("FAIL bp_resume: rd_en=%b data=%h, want 00010/%h", rd_en, out_data, p[1]);
    end
    wait_idle("bp");
  endtask

  task automatic test_empty_stall();
    do_reset();
    push_flit(2, mk(1'b1, 1'b0, 16'h2200));
    push_flit(2, mk(1'b0, 1'b0, 16'h2201));
    expect_flit(2, mk(1'b1, 1'b0, 16'h2200));
    expect_flit(2, mk(1'b0, 1'b0, 16'h2201));
    expect_flit(2, mk(1'b0, 1'b1, 16'h2202));
    expect_flit(0, mk(1'b1, 1'b1, 16'h2000));
    wait_cycle();
    push_flit(0, mk(1'b1, 1'b1, 16'h2000));
    wait_cycle();
    for (int k = 0; k < 5; k++) begin
      wait_cycle();
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || grant_idx !== 3'd2 || rd_en !== '0) begin
        tests_failed++;
        $display("FAIL empty_stall[%0d]: valid=%b busy=%b grant=%0d rd_en=%b, want 0/1/2/00000",
                 k, out_valid, busy, grant_idx, rd_en);
      end
    end
    wait_cycle();
    push_flit(2, mk(1'b0, 1'b1, 16'h2202));
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || rd_en !== 5'b00100) begin
      tests_failed++;
      $display("FAIL empty_refill: valid=%b rd_en=%b, want 1/00100", out_valid, rd_en);
    end
    wait_cycle();
    tests_run++;
    if (busy !== 1'b0 || pkt_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL empty_done: busy=%b pkt_cnt=%0d, want 0/1", busy, pkt_cnt);
    end
    wait_idle("empty");
    tests_run++;
    if (pkt_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL empty_pkt_cnt: got %0d, want 2", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] g [3];
    logic [DATA_W-1:0] h;
    do_reset();
    push_flit(2, mk(1'b1, 1'b1, 16'h3302));
    expect_flit(2, mk(1'b1, 1'b1, 16'h3302));
    wait_idle("mid_pre");
    g[0] = mk(1'b1, 1'b0, 16'h3300);
    g[1] = mk(1'b0, 1'b0, 16'h3301);
    g[2] = mk(1'b0, 1'b1, 16'h3302);
    h    = mk(1'b1, 1'b1, 16'h3310);
    for (int k = 0; k < 3; k++) push_flit(3, g[k]);
    expect_flit(3, g[0]);
    wait_cycle();
    push_flit(1, h);
    wait_cycle();
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (rd_en !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== '0 || grant_idx !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: rd_en=%b valid=%b busy=%b pkt_cnt=%0d grant=%0d, want all 0",
               rd_en, out_valid, busy, pkt_cnt, grant_idx);
    end
    exp_q.delete();
    expect_flit(1, h);
    expect_flit(3, g[1]);
    expect_flit(3, g[2]);
    rst = 1'b1;
    wait_cycle();
    tests_run++;
    if (grant_idx !== 3'd1) begin
      tests_failed++;
      $display("FAIL mid_restart: grant=%0d, want 1", grant_idx);
    end
    wait_idle("mid");
    tests_run++;
    if (pkt_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL mid_pkt_cnt: got %0d, want 2", pkt_cnt);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    out_full = 1'b0;
    req_hit = '1;
    req_empty = '1;
    req_data = '0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_empty_stall();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
